// File: rtl/gate_truth_checker.sv
// Clocked stimulus/response sequencer that walks a 2-input gate through all four
// input vectors and grades its output. Define GATE_CHK_FIRST_FAIL_EN for first-mismatch capture ports.
module gate_truth_checker #(
  parameter int         SETTLE_CYCLES = 1,
  parameter logic [3:0] TRUTH_TABLE   = 4'b1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       op,
  output logic       input1,
  output logic       input2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] vec_idx,
  output logic       sample_valid,
  output logic       sample_match
`ifdef GATE_CHK_FIRST_FAIL_EN
  ,
  output logic       first_fail_valid,
  output logic [1:0] first_fail_idx,
  output logic       first_fail_op
`endif
);

  localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int CNT_W      = ($clog2(SETTLE_EFF) < 1) ? 1 : $clog2(SETTLE_EFF);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_EFF - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       vec_idx_q, vec_idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [2:0]       err_count_q, err_count_d;
  logic             sample_valid_q, sample_valid_d;
  logic             sample_match_q, sample_match_d;

  logic             accept_s;
  logic             sample_s;
  logic             last_vec_s;
  logic             match_s;
  logic [2:0]       err_next_s;

`ifdef GATE_CHK_FIRST_FAIL_EN
  logic             ff_valid_q, ff_valid_d;
  logic [1:0]       ff_idx_q, ff_idx_d;
  logic             ff_op_q, ff_op_d;
`endif

  function automatic logic expected_op(input logic [1:0] idx);
    return TRUTH_TABLE[idx];
  endfunction

  // Strobes shared by the next-state and datapath logic; X/Z on op never matches.
  always_comb begin
    accept_s   = start && (state_q != S_RUN);
    sample_s   = (state_q == S_RUN) && (cnt_q == CNT_LAST);
    last_vec_s = (vec_idx_q == 2'd3);
    match_s    = (op === expected_op(vec_idx_q));
    if (match_s) begin
      err_next_s = err_count_q;
    end else begin
      err_next_s = err_count_q + 3'd1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      vec_idx_q      <= 2'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      err_count_q    <= 3'd0;
      sample_valid_q <= 1'b0;
      sample_match_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      vec_idx_q      <= vec_idx_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      pass_q         <= pass_d;
      err_count_q    <= err_count_d;
      sample_valid_q <= sample_valid_d;
      sample_match_q <= sample_match_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (sample_s && last_vec_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (accept_s) begin
          state_d = S_RUN;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output/datapath next values; the final verdict folds in the last sample.
  always_comb begin
    cnt_d          = cnt_q;
    vec_idx_d      = vec_idx_q;
    busy_d         = busy_q;
    done_d         = done_q;
    pass_d         = pass_q;
    err_count_d    = err_count_q;
    sample_valid_d = 1'b0;
    sample_match_d = sample_match_q;
    if (accept_s) begin
      cnt_d       = '0;
      vec_idx_d   = 2'd0;
      busy_d      = 1'b1;
      done_d      = 1'b0;
      pass_d      = 1'b0;
      err_count_d = 3'd0;
    end else if (state_q == S_RUN) begin
      if (sample_s) begin
        sample_valid_d = 1'b1;
        sample_match_d = match_s;
        err_count_d    = err_next_s;
        cnt_d          = '0;
        if (last_vec_s) begin
          vec_idx_d = 2'd0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          pass_d    = (err_next_s == 3'd0);
        end else begin
          vec_idx_d = vec_idx_q + 2'd1;
        end
      end else begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

`ifdef GATE_CHK_FIRST_FAIL_EN
  // First-mismatch capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ff_valid_q <= 1'b0;
      ff_idx_q   <= 2'd0;
      ff_op_q    <= 1'b0;
    end else begin
      ff_valid_q <= ff_valid_d;
      ff_idx_q   <= ff_idx_d;
      ff_op_q    <= ff_op_d;
    end
  end

  // Latch only the first mismatch of a run; a new run clears the record.
  always_comb begin
    ff_valid_d = ff_valid_q;
    ff_idx_d   = ff_idx_q;
    ff_op_d    = ff_op_q;
    if (accept_s) begin
      ff_valid_d = 1'b0;
      ff_idx_d   = 2'd0;
      ff_op_d    = 1'b0;
    end else if (sample_s && !match_s && !ff_valid_q) begin
      ff_valid_d = 1'b1;
      ff_idx_d   = vec_idx_q;
      ff_op_d    = op;
    end else begin
      ff_valid_d = ff_valid_q;
    end
  end

  assign first_fail_valid = ff_valid_q;
  assign first_fail_idx   = ff_idx_q;
  assign first_fail_op    = ff_op_q;
`endif

  assign input1       = vec_idx_q[0];
  assign input2       = vec_idx_q[1];
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign err_count    = err_count_q;
  assign vec_idx      = vec_idx_q;
  assign sample_valid = sample_valid_q;
  assign sample_match = sample_match_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Randomized bench: four checker instances with different settle/truth-table settings,
// each driving a simulated gate, graded against a vector-level reference model.
module tb_gate_truth_checker;

  localparam int         SV  [4] = '{1, 3, 1, 0};
  localparam logic [3:0] TTV [4] = '{4'b1000, 4'b1000, 4'b0110, 4'b1110};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [3:0]      start_a, op_a, in1_a, in2_a, busy_a, done_a, pass_a, sv_a, sm_a;
  logic [3:0][2:0] err_a;
  logic [3:0][1:0] vidx_a;
  logic [3:0]      gate_tt [4];
`ifdef GATE_CHK_FIRST_FAIL_EN
  logic [3:0]      ffv_a, ffo_a;
  logic [3:0][1:0] ffi_a;
`endif

  int n_total = 0;
  int n_bad   = 0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    assign op_a[gi] = gate_tt[gi][{in2_a[gi], in1_a[gi]}];
    gate_truth_checker #(
      .SETTLE_CYCLES(SV[gi]),
      .TRUTH_TABLE  (TTV[gi])
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start_a[gi]),
      .op          (op_a[gi]),
      .input1      (in1_a[gi]),
      .input2      (in2_a[gi]),
      .busy        (busy_a[gi]),
      .done        (done_a[gi]),
      .pass        (pass_a[gi]),
      .err_count   (err_a[gi]),
      .vec_idx     (vidx_a[gi]),
      .sample_valid(sv_a[gi]),
      .sample_match(sm_a[gi])
`ifdef GATE_CHK_FIRST_FAIL_EN
      ,
      .first_fail_valid(ffv_a[gi]),
      .first_fail_idx  (ffi_a[gi]),
      .first_fail_op   (ffo_a[gi])
`endif
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic string tg(input int k, input string n);
    return $sformatf("d%0d_%s", k, n);
  endfunction

  function automatic int s_of(input int k);
    return (SV[k] < 1) ? 1 : SV[k];
  endfunction

  // Mismatches among the first n vectors of a gate g graded against table t.
  function automatic int mism(input logic [3:0] g, input logic [3:0] t, input int n);
    int cnt = 0;
    for (int i = 0; i < n; i++) if (g[i] != t[i]) cnt++;
    return cnt;
  endfunction

  function automatic int first_mism(input logic [3:0] g, input logic [3:0] t);
    for (int i = 0; i < 4; i++) if (g[i] != t[i]) return i;
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_all();
    for (int k = 0; k < 4; k++) begin
      check_eq(tg(k, "rst_in1"), 32'(in1_a[k]), 32'd0);
      check_eq(tg(k, "rst_in2"), 32'(in2_a[k]), 32'd0);
      check_eq(tg(k, "rst_busy"), 32'(busy_a[k]), 32'd0);
      check_eq(tg(k, "rst_done"), 32'(done_a[k]), 32'd0);
      check_eq(tg(k, "rst_pass"), 32'(pass_a[k]), 32'd0);
      check_eq(tg(k, "rst_err"), 32'(err_a[k]), 32'd0);
      check_eq(tg(k, "rst_vidx"), 32'(vidx_a[k]), 32'd0);
      check_eq(tg(k, "rst_sv"), 32'(sv_a[k]), 32'd0);
      check_eq(tg(k, "rst_sm"), 32'(sm_a[k]), 32'd0);
`ifdef GATE_CHK_FIRST_FAIL_EN
      check_eq(tg(k, "rst_ffv"), 32'(ffv_a[k]), 32'd0);
`endif
    end
  endtask

  // One complete run on instance k with simulated gate g, checked every cycle.
  task automatic run(input int k, input logic [3:0] g);
    int s;
    int e;
    int nh;
    logic [3:0] t;
    s = s_of(k);
    t = TTV[k];
    gate_tt[k] = g;
    start_a[k] = 1'b1;
    step();
    start_a[k] = 1'b0;
    for (int c = 0; c < 4 * s; c++) begin
      int v;
      v = c / s;
      check_eq(tg(k, "busy"), 32'(busy_a[k]), 32'd1);
      check_eq(tg(k, "done"), 32'(done_a[k]), 32'd0);
      check_eq(tg(k, "pass"), 32'(pass_a[k]), 32'd0);
      check_eq(tg(k, "vidx"), 32'(vidx_a[k]), 32'(v));
      check_eq(tg(k, "in1"), 32'(in1_a[k]), 32'(v % 2));
      check_eq(tg(k, "in2"), 32'(in2_a[k]), 32'(v / 2));
      check_eq(tg(k, "err"), 32'(err_a[k]), 32'(mism(g, t, v)));
      check_eq(tg(k, "sv"), 32'(sv_a[k]), 32'((c > 0) && (c % s == 0)));
      if (c > 0 && c % s == 0) begin
        check_eq(tg(k, "sm"), 32'(sm_a[k]), 32'(g[v-1] == t[v-1]));
      end
      // Start while busy must be ignored.
      start_a[k] = ($urandom_range(0, 3) == 0);
      step();
    end
    start_a[k] = 1'b0;
    e = mism(g, t, 4);
    check_eq(tg(k, "fin_done"), 32'(done_a[k]), 32'd1);
    check_eq(tg(k, "fin_busy"), 32'(busy_a[k]), 32'd0);
    check_eq(tg(k, "fin_sv"), 32'(sv_a[k]), 32'd1);
    check_eq(tg(k, "fin_sm"), 32'(sm_a[k]), 32'(g[3] == t[3]));
    check_eq(tg(k, "fin_err"), 32'(err_a[k]), 32'(e));
    check_eq(tg(k, "fin_pass"), 32'(pass_a[k]), 32'(e == 0));
    check_eq(tg(k, "fin_vidx"), 32'(vidx_a[k]), 32'd0);
    check_eq(tg(k, "fin_in"), 32'({in2_a[k], in1_a[k]}), 32'd0);
`ifdef GATE_CHK_FIRST_FAIL_EN
    check_eq(tg(k, "ffv"), 32'(ffv_a[k]), 32'(e > 0));
    if (e > 0) begin
      check_eq(tg(k, "ffi"), 32'(ffi_a[k]), 32'(first_mism(g, t)));
      check_eq(tg(k, "ffo"), 32'(ffo_a[k]), 32'(g[first_mism(g, t)]));
    end
`endif
    nh = $urandom_range(1, 3);
    for (int h = 0; h < nh; h++) begin
      step();
      check_eq(tg(k, "hold_done"), 32'(done_a[k]), 32'd1);
      check_eq(tg(k, "hold_busy"), 32'(busy_a[k]), 32'd0);
      check_eq(tg(k, "hold_sv"), 32'(sv_a[k]), 32'd0);
      check_eq(tg(k, "hold_err"), 32'(err_a[k]), 32'(e));
      check_eq(tg(k, "hold_pass"), 32'(pass_a[k]), 32'(e == 0));
    end
  endtask

  // Start a run, reset it while vector 2 is driven, then expect reset values everywhere.
  task automatic run_abort(input int k, input logic [3:0] g);
    int s;
    s = s_of(k);
    gate_tt[k] = g;
    start_a[k] = 1'b1;
    step();
    start_a[k] = 1'b0;
    for (int c = 0; c < 2 * s; c++) step();
    check_eq(tg(k, "abort_vidx"), 32'(vidx_a[k]), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_all();
  endtask

  initial begin
    rst     = 1'b1;
    start_a = 4'd0;
    for (int k = 0; k < 4; k++) gate_tt[k] = 4'd0;
    repeat (3) step();
    rst = 1'b0;
    check_reset_all();

    run(0, 4'b1000);
    run(0, 4'b1111);
    run(2, 4'b1000);
    run(1, 4'b1000);
    run(3, 4'b1110);
    run_abort(0, 4'b1000);
    run(0, 4'b1000);
    run(0, 4'b1000);
    run(3, 4'b0000);

    for (int it = 0; it < 40; it++) begin
      int k;
      logic [3:0] g;
      k = $urandom_range(0, 3);
      g = ($urandom_range(0, 1) == 1) ? TTV[k] : 4'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        run_abort(k, g);
      end else begin
        run(k, g);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
